// File: rtl/rs_enc_lfsr.sv
// Systematic Reed-Solomon encoder: message symbols pass through, 2*T_LEN LFSR parity symbols follow.
// Latency: message symbols 0 cycles (combinational); first parity symbol the cycle after the last message handshake.
// Backpressure: in_ready mirrors out_ready while in the message phase; in the parity phase, output holds while !out_ready.

package gf_pkg;
    // GF(2^8) built on the primitive polynomial x^8 + x^4 + x^3 + x^2 + 1
    localparam int                  SYMB_WIDTH = 8;
    localparam int                  T_LEN      = 2;
    localparam logic [SYMB_WIDTH:0] PRIM_POLY  = 9'h11D;

    // Carry-less shift-and-add multiply, reduced modulo PRIM_POLY on every shift
    function automatic logic [SYMB_WIDTH-1:0] gf_mult(
        input logic [SYMB_WIDTH-1:0] a,
        input logic [SYMB_WIDTH-1:0] b
    );
        logic [SYMB_WIDTH-1:0] acc;
        logic [SYMB_WIDTH-1:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < SYMB_WIDTH; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            if (sh[SYMB_WIDTH-1]) begin
                sh = (sh << 1) ^ PRIM_POLY[SYMB_WIDTH-1:0];
            end else begin
                sh = sh << 1;
            end
        end
        return acc;
    endfunction
endpackage

module rs_enc_lfsr #(
    parameter int SYMB_WIDTH = gf_pkg::SYMB_WIDTH,
    parameter int T_LEN      = gf_pkg::T_LEN,
    parameter int N_LEN      = (1 << SYMB_WIDTH) - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SYMB_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SYMB_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  len_err
);

    localparam int P     = 2 * T_LEN;
    localparam int K_MAX = N_LEN - P;
    localparam int CW    = $clog2(N_LEN + 1);
    localparam int PW    = (P > 1) ? $clog2(P) : 1;

    // Generator g(x) = prod_{i=0}^{P-1} (x - alpha^i), built one root at a time.
    // Returns g[0..P-1] packed low-degree first; the monic x^P term is implicit.
    function automatic logic [P*SYMB_WIDTH-1:0] gen_poly();
        logic [SYMB_WIDTH-1:0]   c [P+1];
        logic [SYMB_WIDTH-1:0]   root;
        logic [P*SYMB_WIDTH-1:0] flat;
        for (int j = 0; j <= P; j++) begin
            c[j] = '0;
        end
        c[0] = SYMB_WIDTH'(1);
        root = SYMB_WIDTH'(1);
        for (int i = 0; i < P; i++) begin
            // multiply running product by (x + root); subtraction is XOR in GF(2^m)
            for (int j = P; j >= 1; j--) begin
                c[j] = c[j-1] ^ gf_pkg::gf_mult(c[j], root);
            end
            c[0] = gf_pkg::gf_mult(c[0], root);
            root = gf_pkg::gf_mult(root, SYMB_WIDTH'(2));
        end
        flat = '0;
        for (int j = 0; j < P; j++) begin
            flat[j*SYMB_WIDTH +: SYMB_WIDTH] = c[j];
        end
        return flat;
    endfunction

    localparam logic [P*SYMB_WIDTH-1:0] G_FLAT = gen_poly();

    typedef enum logic {
        ST_MSG    = 1'b0,
        ST_PARITY = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [SYMB_WIDTH-1:0] r_q [P];
    logic [SYMB_WIDTH-1:0] r_d [P];
    logic [CW-1:0]         msg_cnt_q, msg_cnt_d;
    logic [PW-1:0]         par_cnt_q, par_cnt_d;
    logic                  len_err_q, len_err_d;
    logic [SYMB_WIDTH-1:0] fb;
    logic                  msg_hs;
    logic                  at_kmax;

    // State, LFSR, counters and the registered overrun pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_MSG;
            msg_cnt_q <= '0;
            par_cnt_q <= '0;
            len_err_q <= 1'b0;
            for (int i = 0; i < P; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            msg_cnt_q <= msg_cnt_d;
            par_cnt_q <= par_cnt_d;
            len_err_q <= len_err_d;
            for (int i = 0; i < P; i++) begin
                r_q[i] <= r_d[i];
            end
        end
    end

    // Next-state, LFSR update and handshake outputs for the two phases
    always_comb begin
        state_d   = state_q;
        msg_cnt_d = msg_cnt_q;
        par_cnt_d = par_cnt_q;
        len_err_d = 1'b0;
        for (int i = 0; i < P; i++) begin
            r_d[i] = r_q[i];
        end
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        fb        = in_data ^ r_q[P-1];
        msg_hs    = 1'b0;
        at_kmax   = (msg_cnt_q == CW'(K_MAX - 1));

        case (state_q)
            ST_MSG: begin
                // pass-through: the downstream sink paces the source directly
                in_ready  = out_ready;
                out_valid = in_valid;
                out_data  = in_data;
                msg_hs    = in_valid && out_ready;
                if (msg_hs) begin
                    r_d[0] = gf_pkg::gf_mult(fb, G_FLAT[0 +: SYMB_WIDTH]);
                    for (int i = 1; i < P; i++) begin
                        r_d[i] = r_q[i-1] ^ gf_pkg::gf_mult(fb, G_FLAT[i*SYMB_WIDTH +: SYMB_WIDTH]);
                    end
                    msg_cnt_d = msg_cnt_q + 1'b1;
                    if (in_last || at_kmax) begin
                        state_d   = ST_PARITY;
                        par_cnt_d = '0;
                        // hitting the length cap without in_last forcibly closes the message
                        len_err_d = !in_last;
                    end
                end
            end
            ST_PARITY: begin
                out_valid = 1'b1;
                out_data  = r_q[P-1];
                out_last  = (par_cnt_q == PW'(P - 1));
                if (out_ready) begin
                    // shifting in zeros leaves the LFSR cleared after the last parity symbol
                    r_d[0] = '0;
                    for (int i = 1; i < P; i++) begin
                        r_d[i] = r_q[i-1];
                    end
                    par_cnt_d = par_cnt_q + 1'b1;
                    if (out_last) begin
                        state_d   = ST_MSG;
                        msg_cnt_d = '0;
                        par_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_MSG;
            end
        endcase
    end

    assign len_err = len_err_q;

endmodule

// File: tb/tb_rs_enc_lfsr.sv
// Scoreboard bench for rs_enc_lfsr with T_LEN=2 over GF(2^8)/0x11D.
// Expected codewords come from textbook polynomial long division; a monitor checks outputs and syndromes.
// Random out_ready backpressure and random source gaps; stalled outputs must hold steady.

module tb_rs_enc_lfsr;

    localparam int W     = 8;
    localparam int P     = 4;
    localparam int N_LEN = 255;
    localparam int K_MAX = N_LEN - P;

    // g(x) coefficients indexed by degree, monic at x^4
    localparam logic [7:0] G_C [0:4] = '{8'h40, 8'h78, 8'h36, 8'h0F, 8'h01};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         len_err;

    int           n_vec = 0;
    int           n_err = 0;
    int           len_err_cnt = 0;
    bit           bp_en = 1'b0;
    logic [8:0]   sb [$];
    logic [7:0]   obs_cw [$];

    always #5 clk = ~clk;

    rs_enc_lfsr #(.SYMB_WIDTH(W), .T_LEN(2), .N_LEN(N_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .len_err   (len_err)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] x;
        logic [7:0] p;
        x = {1'b0, a};
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x[7:0];
            x = x << 1;
            if (x[8]) x = x ^ 9'h11D;
        end
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected codeword: message followed by remainder of m(x)*x^P divided by g(x)
    task automatic push_codeword(input logic [7:0] m [$]);
        logic [7:0] poly [];
        int         k;
        logic [7:0] c;
        k = m.size();
        poly = new[k + P];
        for (int i = 0; i < k + P; i++) poly[i] = (i < k) ? m[i] : 8'h00;
        for (int idx = 0; idx < k; idx++) begin
            c = poly[idx];
            for (int j = 1; j <= P; j++) poly[idx+j] = poly[idx+j] ^ gmul(c, G_C[P-j]);
        end
        for (int i = 0; i < k; i++) sb.push_back({1'b0, m[i]});
        for (int i = 0; i < P; i++) sb.push_back({(i == P - 1), poly[k+i]});
    endtask

    task automatic drive_sym(input logic [7:0] d, input logic l);
        int  t;
        bit  done;
        t    = 0;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
            end else begin
                t++;
                if (t > 2000) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL in_handshake_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, t);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Model splits the stream into codewords at in_last or at K_MAX, then drives it
    task automatic send_stream(input logic [7:0] syms [$], input bit last_at_end, input bit gaps);
        logic [7:0] cur [$];
        int         n;
        n = syms.size();
        for (int i = 0; i < n; i++) begin
            cur.push_back(syms[i]);
            if ((last_at_end && i == n - 1) || cur.size() == K_MAX) begin
                push_codeword(cur);
                cur.delete();
            end
        end
        for (int i = 0; i < n; i++) begin
            drive_sym(syms[i], last_at_end && (i == n - 1));
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check(name, sb.size(), 0);
    endtask

    // Sink readiness: random at 50% when backpressure is enabled
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Monitor: scoreboard compare, stall stability, per-codeword syndromes, len_err count
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        logic [8:0] e;
        logic [7:0] s;
        logic [7:0] a;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                obs_cw.delete();
            end else begin
                if (len_err) len_err_cnt++;
                if (prev_stall) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, prev_data);
                    check("stall_last", out_last, prev_last);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_output: data 0x%0h last %0b, scoreboard empty", out_data, out_last);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", out_data, e[7:0]);
                        check("out_last", out_last, e[8]);
                    end
                    obs_cw.push_back(out_data);
                    if (out_last) begin
                        a = 8'h01;
                        for (int i = 0; i < P; i++) begin
                            s = 8'h00;
                            foreach (obs_cw[k]) s = gmul(s, a) ^ obs_cw[k];
                            check($sformatf("syndrome_%0d", i), s, 0);
                            a = gmul(a, 8'h02);
                        end
                        obs_cw.delete();
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, %0d expected symbols pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] syms [$];
        logic [7:0] d;
        int         len;
        int         le0;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, out_ready);
        check("rst_len_err", len_err, 0);
        check("rst_out_last", out_last, 0);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        #1;
        check("rst_passthru_valid", out_valid, 1);
        check("rst_passthru_data", out_data, 8'hA5);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single symbol 0x01 -> parity equals the generator coefficients
        sb.push_back({1'b0, 8'h01});
        sb.push_back({1'b0, 8'h0F});
        sb.push_back({1'b0, 8'h36});
        sb.push_back({1'b0, 8'h78});
        sb.push_back({1'b1, 8'h40});
        drive_sym(8'h01, 1'b1);
        wait_drain("drain_single");

        // all-zero message of 10 symbols -> 14 zeros, last on the 14th
        for (int i = 0; i < 14; i++) sb.push_back({(i == 13), 8'h00});
        for (int i = 0; i < 10; i++) drive_sym(8'h00, i == 9);
        wait_drain("drain_zero");

        // back-to-back single-symbol messages, in_valid held high
        for (int k = 0; k < 6; k++) begin
            syms.delete();
            syms.push_back(8'(8'h10 + k));
            push_codeword(syms);
        end
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = 8'h10;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("b2b_ready_msg", in_ready, 1);
            @(posedge clk);
            #1;
            if (k == 5) in_valid = 1'b0;
            else        in_data  = 8'(8'h11 + k);
            for (int c = 0; c < P; c++) begin
                @(negedge clk);
                check("b2b_ready_par", in_ready, 0);
                @(posedge clk);
                #1;
            end
        end
        in_last = 1'b0;
        wait_drain("drain_b2b");

        // full-length legal message: in_last on the K_MAX-th symbol
        le0 = len_err_cnt;
        syms.delete();
        for (int i = 0; i < K_MAX; i++) syms.push_back(8'($urandom_range(0, 255)));
        send_stream(syms, 1'b1, 1'b0);
        wait_drain("drain_full");
        check("len_err_full", len_err_cnt - le0, 0);

        // overrun: K_MAX+3 symbols, in_last only on the final one
        le0 = len_err_cnt;
        syms.delete();
        for (int i = 0; i < K_MAX + 3; i++) syms.push_back(8'($urandom_range(0, 255)));
        send_stream(syms, 1'b1, 1'b0);
        wait_drain("drain_overrun");
        check("len_err_overrun", len_err_cnt - le0, 1);

        // random codewords under 50% backpressure with source gaps
        bp_en = 1'b1;
        for (int c = 0; c < 120; c++) begin
            if (c % 2 == 1) len = $urandom_range(1, K_MAX);
            else            len = $urandom_range(1, 16);
            syms.delete();
            for (int i = 0; i < len; i++) syms.push_back(8'($urandom_range(0, 255)));
            send_stream(syms, 1'b1, 1'b1);
        end
        wait_drain("drain_random");
        bp_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset during the second parity symbol
        sb.push_back({1'b0, 8'h01});
        sb.push_back({1'b0, 8'h0F});
        sb.push_back({1'b0, 8'h36});
        sb.push_back({1'b0, 8'h78});
        sb.push_back({1'b1, 8'h40});
        drive_sym(8'h01, 1'b1);
        @(posedge clk);
        #2;
        check("rst_mid_pos", sb.size(), 3);
        check("rst_mid_pre_data", out_data, 8'h36);
        rst      = 1'b1;
        d        = 8'($urandom_range(0, 255));
        in_valid = 1'b1;
        in_data  = d;
        #1;
        check("rst_mid_out_valid", out_valid, 1);
        check("rst_mid_out_data", out_data, d);
        check("rst_mid_out_last", out_last, 0);
        check("rst_mid_len_err", len_err, 0);
        in_valid = 1'b0;
        #1;
        check("rst_mid_out_valid_lo", out_valid, 0);
        sb.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.push_back({1'b0, 8'h01});
        sb.push_back({1'b0, 8'h0F});
        sb.push_back({1'b0, 8'h36});
        sb.push_back({1'b0, 8'h78});
        sb.push_back({1'b1, 8'h40});
        drive_sym(8'h01, 1'b1);
        wait_drain("drain_after_rst");

        check("len_err_total", len_err_cnt, 1);
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
